sd_host_reg_bank: RTL and testbench
===================================

Name: sd_host_reg_bank

Overview:
Parametrised host-controller register bank, successor to the fixed reg_16/reg_32/reg_64 instances with a separate start detector. It provides a byte-strobed 32-bit CPU access port and an SD-Host-style register map with W1C interrupt status, status/signal enables and hardware update ports. It also generates the command start pulse and the interrupt line. It feeds the dma, CMD and DAT blocks and collects their status.

Parameters:
ADDR_W, 12, CPU byte-address width
NUM_RESP_WORDS, 4, 32-bit response words at 0x010 upward (1..4)
ADMA_ADDR_W, 64, ADMA system address width (32 or 64)
BLK_SZ_W, 12, implemented block-size bits

Ports:
CLK  in  1  clock; the only clock
RESET  in  1  synchronous, active-high reset
reg_address  in  ADDR_W  byte address; bits [1:0] ignored
reg_wr_data  in  32  CPU write data
reg_wr_strb  in  4  byte strobes
reg_wr_en  in  1  write request, one cycle
reg_rd_en  in  1  read request, one cycle
reg_rd_data  out  32  registered read data
reg_rd_valid  out  1  read data valid
psr_in  in  32  live present-state bits from CMD/DAT
nisr_set  in  15  normal-status set pulses, bits [14:0]
eisr_set  in  16  error-status set pulses
blk_cnt_dec  in  1  DAT block-done decrement
resp_wr_en  in  NUM_RESP_WORDS  response word load
resp_wr_data  in  32*NUM_RESP_WORDS  response load data
adma_err_ld  in  1  ADMA error register load
adma_err_in  in  8  ADMA error value
blk_size  out  BLK_SZ_W  0x004[BLK_SZ_W-1:0]
blk_cnt  out  16  0x006
argument  out  32  0x008
transfer_mode  out  16  0x00C
command  out  16  0x00E
bgcr  out  16  0x02A
adma_addr  out  ADMA_ADDR_W  0x058/0x05C
start_flag  out  1  one-cycle command start pulse
irq  out  1  registered interrupt request

Behaviour:
- RESET: every register, reg_rd_data, reg_rd_valid, start_flag and irq are cleared to 0.
- Register map (word address):
  - 0x004: BSR[15:0], BCR[31:16]; RW.
  - 0x008: ARG; RW.
  - 0x00C: TMR[15:0], CMD[31:16]; RW.
  - 0x010+4k: RESPk; RO.
  - 0x024: PSR; RO, reads psr_in directly.
  - 0x028: BGCR[31:16]; RW.
  - 0x030: NISR[15:0], EISR[31:16]; W1C.
  - 0x034: NISR/EISR status enable; RW.
  - 0x038: NISR/EISR signal enable; RW.
  - 0x054: ADMA error [7:0]; RO.
  - 0x058: ADMASAR low; RW.
  - 0x05C: ADMASAR high; RW.
- Unmapped addresses: reads return 0, writes are ignored.
- With ADMA_ADDR_W=32, 0x05C reads 0 and writes to it are ignored.
- BSR bits above BLK_SZ_W read 0.
- Writes: each byte lane updates only when its strobe is set, in the same edge as reg_wr_en.
- Reads: reg_rd_data and reg_rd_valid are presented 1 cycle after reg_rd_en; reg_rd_valid is high for exactly 1 cycle. A read carries no side effects.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- NISR/EISR status bits:
  - A bit sets on a set pulse only if its status-enable bit is 1; otherwise the pulse is dropped.
  - CPU write of 1 clears the bit.
  - Hardware set and CPU clear in the same cycle: set wins.
  - NISR[15] is RO and equals |EISR.
- irq is registered: irq <= |(NISR[14:0] & NSIG[14:0]) | |(EISR & ESIG). It follows status by 1 cycle.
- Block count:
  - blk_cnt_dec decrements BCR, saturating at 0.
  - A CPU write to the BCR bytes in the same cycle wins; the decrement is lost.
- Response words: resp_wr_en[k] loads RESPk. The CPU cannot write them.
- Start flag:
  - A CPU write with strb[3]=1 to 0x00C (CMD index byte) produces start_flag high on the following cycle, for exactly 1 cycle.
  - If psr_in[0] (cmd inhibit) is 1 at the time of that write: the CMD and TMR bytes are not updated, no start_flag is produced, and EISR[12] is set (status enable honoured).
  - A back-to-back CMD write produces a second pulse; pulses never merge.
- Reset asserted mid-access: pending reg_rd_valid and start_flag are cancelled on that edge.

Optional Feature:
Macro SD_HOST_REG_WR_PROTECT_EN.
- Defined: while psr_in[1] (DAT inhibit) is 1, CPU writes to BSR, BCR, ARG, TMR and ADMASAR are dropped and EISR[13] is set (status enable honoured). The CMD byte is still governed by the start-flag rule.
- Undefined: these writes always take effect and EISR[13] is never set.

Test Plan:
- Reset, then read 0x004, 0x030 and 0x058 -> reg_rd_data 0x00000000, reg_rd_valid 1 cycle after each reg_rd_en, irq 0.
- Write 0x0001_0200 with strb 4'b0011 to 0x004 -> blk_size 0x200, blk_cnt unchanged at 0; then pulse blk_cnt_dec 2 times after BCR=1 -> blk_cnt 0, not 0xFFFF.
- Status enable 0x0000_0001, signal enable 0x0000_0001, pulse nisr_set[0] -> NISR reads 0x0001, irq 1 one cycle later. Write 0x1 to 0x030 in the same cycle as a new nisr_set[0] -> bit stays 1. Next clear -> irq 0.
- psr_in[0]=0, write 0x1100_0000 strb 4'b1100 to 0x00C -> command 0x1100, single start_flag next cycle. Repeat with psr_in[0]=1 and EISR enable bit 12 set -> command unchanged, no start_flag, EISR 0x1000, NISR[15] reads 1.
- resp_wr_en=4'b0010 with word1=0xDEADBEEF -> read 0x014 returns 0xDEADBEEF. CPU write to 0x014 -> value unchanged.
- With SD_HOST_REG_WR_PROTECT_EN defined and psr_in[1]=1, write 0x12345678 to 0x008 -> argument stays 0, EISR[13] set. Without the macro -> argument 0x12345678.

Source files
------------

// File: rtl/sd_host_reg_bank.sv
// SD host controller register bank: byte-strobed 32-bit CPU port, W1C interrupt status,
// command start pulse and irq. Optional write protection under SD_HOST_REG_WR_PROTECT_EN.
module sd_host_reg_bank #(
    parameter int ADDR_W         = 12,
    parameter int NUM_RESP_WORDS = 4,
    parameter int ADMA_ADDR_W    = 64,
    parameter int BLK_SZ_W       = 12
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ADDR_W-1:0]           reg_address,
    input  logic [31:0]                 reg_wr_data,
    input  logic [3:0]                  reg_wr_strb,
    input  logic                        reg_wr_en,
    input  logic                        reg_rd_en,
    output logic [31:0]                 reg_rd_data,
    output logic                        reg_rd_valid,
    input  logic [31:0]                 psr_in,
    input  logic [14:0]                 nisr_set,
    input  logic [15:0]                 eisr_set,
    input  logic                        blk_cnt_dec,
    input  logic [NUM_RESP_WORDS-1:0]   resp_wr_en,
    input  logic [32*NUM_RESP_WORDS-1:0] resp_wr_data,
    input  logic                        adma_err_ld,
    input  logic [7:0]                  adma_err_in,
    output logic [BLK_SZ_W-1:0]         blk_size,
    output logic [15:0]                 blk_cnt,
    output logic [31:0]                 argument,
    output logic [15:0]                 transfer_mode,
    output logic [15:0]                 command,
    output logic [15:0]                 bgcr,
    output logic [ADMA_ADDR_W-1:0]      adma_addr,
    output logic                        start_flag,
    output logic                        irq
);

    localparam bit ADMA_HI_EN = (ADMA_ADDR_W > 32);

    localparam logic [ADDR_W-1:0] A_BLK  = ADDR_W'('h004);
    localparam logic [ADDR_W-1:0] A_ARG  = ADDR_W'('h008);
    localparam logic [ADDR_W-1:0] A_TMR  = ADDR_W'('h00C);
    localparam logic [ADDR_W-1:0] A_PSR  = ADDR_W'('h024);
    localparam logic [ADDR_W-1:0] A_BGC  = ADDR_W'('h028);
    localparam logic [ADDR_W-1:0] A_ISR  = ADDR_W'('h030);
    localparam logic [ADDR_W-1:0] A_STEN = ADDR_W'('h034);
    localparam logic [ADDR_W-1:0] A_SIG  = ADDR_W'('h038);
    localparam logic [ADDR_W-1:0] A_AERR = ADDR_W'('h054);
    localparam logic [ADDR_W-1:0] A_ALO  = ADDR_W'('h058);
    localparam logic [ADDR_W-1:0] A_AHI  = ADDR_W'('h05C);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [ADDR_W-1:0] addr;
    logic              unused_addr;
    logic              wp_active;

    assign addr        = {reg_address[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^reg_address[1:0];

`ifdef SD_HOST_REG_WR_PROTECT_EN
    assign wp_active = psr_in[1];
`else
    assign wp_active = 1'b0;
`endif

    logic [BLK_SZ_W-1:0] bsr_q, bsr_d;
    logic [15:0]         bcr_q, bcr_d;
    logic [31:0]         arg_q, arg_d;
    logic [15:0]         tmr_q, tmr_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [31:0]         resp_q [NUM_RESP_WORDS];
    logic [31:0]         resp_d [NUM_RESP_WORDS];
    logic [15:0]         bgcr_q, bgcr_d;
    logic [14:0]         nisr_q, nisr_d;
    logic [15:0]         eisr_q, eisr_d;
    logic [31:0]         sten_q, sten_d;
    logic [31:0]         sig_q, sig_d;
    logic [7:0]          aerr_q, aerr_d;
    logic [31:0]         alo_q, alo_d;
    logic [31:0]         ahi_q, ahi_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                start_q, start_d;
    logic                irq_q, irq_d;

    logic [31:0] w_blk, w_tc, rd_mux;
    logic [15:0] bsr_rd, eisr_hw, eisr_clr;
    logic [14:0] nisr_clr;
    logic        cmd_req, cmd_block, tc_ok, wp_err, wr_isr;

    always_comb begin
        bsr_d    = bsr_q;
        bcr_d    = bcr_q;
        arg_d    = arg_q;
        tmr_d    = tmr_q;
        cmd_d    = cmd_q;
        bgcr_d   = bgcr_q;
        sten_d   = sten_q;
        sig_d    = sig_q;
        aerr_d   = adma_err_ld ? adma_err_in : aerr_q;
        alo_d    = alo_q;
        ahi_d    = ahi_q;
        bsr_rd   = 16'(bsr_q);
        w_blk    = merge_bytes({bcr_q, bsr_rd}, reg_wr_data, reg_wr_strb);
        w_tc     = merge_bytes({cmd_q, tmr_q}, reg_wr_data, reg_wr_strb);

        // A blocked command write also freezes the TMR half of the word.
        cmd_req   = reg_wr_en && (addr == A_TMR) && reg_wr_strb[3];
        cmd_block = cmd_req && psr_in[0];
        tc_ok     = reg_wr_en && (addr == A_TMR) && !cmd_block;
        start_d   = cmd_req && !psr_in[0];

        wp_err = wp_active && reg_wr_en &&
                 ((addr == A_BLK) || (addr == A_ARG) || (addr == A_ALO) ||
                  ((addr == A_TMR) && (|reg_wr_strb[1:0])) ||
                  (ADMA_HI_EN && (addr == A_AHI)));

        for (int k = 0; k < NUM_RESP_WORDS; k++) begin
            resp_d[k] = resp_wr_en[k] ? resp_wr_data[32*k +: 32] : resp_q[k];
        end

        // CPU write to BCR takes priority over the DAT decrement.
        if (reg_wr_en && (addr == A_BLK) && !wp_active) begin
            bsr_d = w_blk[BLK_SZ_W-1:0];
            if (|reg_wr_strb[3:2]) bcr_d = w_blk[31:16];
            else if (blk_cnt_dec && (bcr_q != 16'd0)) bcr_d = bcr_q - 16'd1;
        end else if (blk_cnt_dec && (bcr_q != 16'd0)) begin
            bcr_d = bcr_q - 16'd1;
        end

        if (reg_wr_en && (addr == A_ARG) && !wp_active)
            arg_d = merge_bytes(arg_q, reg_wr_data, reg_wr_strb);
        if (tc_ok) begin
            cmd_d = w_tc[31:16];
            if (!wp_active) tmr_d = w_tc[15:0];
        end
        if (reg_wr_en && (addr == A_BGC))
            bgcr_d = merge_bytes({bgcr_q, 16'd0}, reg_wr_data, reg_wr_strb & 4'b1100) >> 16;
        if (reg_wr_en && (addr == A_STEN))
            sten_d = merge_bytes(sten_q, reg_wr_data, reg_wr_strb);
        if (reg_wr_en && (addr == A_SIG))
            sig_d = merge_bytes(sig_q, reg_wr_data, reg_wr_strb);
        if (reg_wr_en && (addr == A_ALO) && !wp_active)
            alo_d = merge_bytes(alo_q, reg_wr_data, reg_wr_strb);
        if (ADMA_HI_EN && reg_wr_en && (addr == A_AHI) && !wp_active)
            ahi_d = merge_bytes(ahi_q, reg_wr_data, reg_wr_strb);

        // W1C status: hardware set wins over a same-cycle CPU clear.
        wr_isr   = reg_wr_en && (addr == A_ISR);
        nisr_clr = wr_isr ? (reg_wr_data[14:0] & {{7{reg_wr_strb[1]}}, {8{reg_wr_strb[0]}}}) : 15'd0;
        eisr_clr = wr_isr ? (reg_wr_data[31:16] & {{8{reg_wr_strb[3]}}, {8{reg_wr_strb[2]}}}) : 16'd0;
        eisr_hw      = eisr_set;
        eisr_hw[12]  = eisr_set[12] | cmd_block;
        eisr_hw[13]  = eisr_set[13] | wp_err;
        nisr_d = (nisr_q & ~nisr_clr) | (nisr_set & sten_q[14:0]);
        eisr_d = (eisr_q & ~eisr_clr) | (eisr_hw & sten_q[31:16]);

        irq_d = (|(nisr_q & sig_q[14:0])) | (|(eisr_q & sig_q[31:16]));

        rd_mux = 32'd0;
        case (addr)
            A_BLK:  rd_mux = {bcr_q, bsr_rd};
            A_ARG:  rd_mux = arg_q;
            A_TMR:  rd_mux = {cmd_q, tmr_q};
            A_PSR:  rd_mux = psr_in;
            A_BGC:  rd_mux = {bgcr_q, 16'd0};
            A_ISR:  rd_mux = {eisr_q, |eisr_q, nisr_q};
            A_STEN: rd_mux = sten_q;
            A_SIG:  rd_mux = sig_q;
            A_AERR: rd_mux = {24'd0, aerr_q};
            A_ALO:  rd_mux = alo_q;
            A_AHI:  rd_mux = ahi_q;
            default: rd_mux = 32'd0;
        endcase
        for (int k = 0; k < NUM_RESP_WORDS; k++) begin
            if (addr == ADDR_W'(16 + 4 * k)) rd_mux = resp_q[k];
        end

        // Read port: reg_rd_en is a one-cycle request with no backpressure;
        // reg_rd_valid answers it exactly one cycle later for one cycle.
        rd_valid_d = reg_rd_en;
        rd_data_d  = reg_rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bsr_q      <= '0;
            bcr_q      <= '0;
            arg_q      <= '0;
            tmr_q      <= '0;
            cmd_q      <= '0;
            for (int k = 0; k < NUM_RESP_WORDS; k++) resp_q[k] <= '0;
            bgcr_q     <= '0;
            nisr_q     <= '0;
            eisr_q     <= '0;
            sten_q     <= '0;
            sig_q      <= '0;
            aerr_q     <= '0;
            alo_q      <= '0;
            ahi_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            bsr_q      <= bsr_d;
            bcr_q      <= bcr_d;
            arg_q      <= arg_d;
            tmr_q      <= tmr_d;
            cmd_q      <= cmd_d;
            for (int k = 0; k < NUM_RESP_WORDS; k++) resp_q[k] <= resp_d[k];
            bgcr_q     <= bgcr_d;
            nisr_q     <= nisr_d;
            eisr_q     <= eisr_d;
            sten_q     <= sten_d;
            sig_q      <= sig_d;
            aerr_q     <= aerr_d;
            alo_q      <= alo_d;
            ahi_q      <= ahi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_rd_data   = rd_data_q;
    assign reg_rd_valid  = rd_valid_q;
    assign blk_size      = bsr_q;
    assign blk_cnt       = bcr_q;
    assign argument      = arg_q;
    assign transfer_mode = tmr_q;
    assign command       = cmd_q;
    assign bgcr          = bgcr_q;
    assign adma_addr     = ADMA_ADDR_W'({ahi_q, alo_q});
    assign start_flag    = start_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_sd_host_reg_bank.sv
// Directed self-checking bench for sd_host_reg_bank (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sd_host_reg_bank;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [11:0]  reg_address = '0;
    logic [31:0]  reg_wr_data = '0;
    logic [3:0]   reg_wr_strb = '0;
    logic         reg_wr_en = 1'b0;
    logic         reg_rd_en = 1'b0;
    logic [31:0]  reg_rd_data;
    logic         reg_rd_valid;
    logic [31:0]  psr_in = '0;
    logic [14:0]  nisr_set = '0;
    logic [15:0]  eisr_set = '0;
    logic         blk_cnt_dec = 1'b0;
    logic [3:0]   resp_wr_en = '0;
    logic [127:0] resp_wr_data = '0;
    logic         adma_err_ld = 1'b0;
    logic [7:0]   adma_err_in = '0;
    logic [11:0]  blk_size;
    logic [15:0]  blk_cnt;
    logic [31:0]  argument;
    logic [15:0]  transfer_mode;
    logic [15:0]  command;
    logic [15:0]  bgcr;
    logic [63:0]  adma_addr;
    logic         start_flag;
    logic         irq;

    int checks = 0;
    int failures = 0;

    sd_host_reg_bank dut (
        .CLK(CLK), .RESET(RESET),
        .reg_address(reg_address), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .psr_in(psr_in), .nisr_set(nisr_set), .eisr_set(eisr_set),
        .blk_cnt_dec(blk_cnt_dec), .resp_wr_en(resp_wr_en), .resp_wr_data(resp_wr_data),
        .adma_err_ld(adma_err_ld), .adma_err_in(adma_err_in),
        .blk_size(blk_size), .blk_cnt(blk_cnt), .argument(argument),
        .transfer_mode(transfer_mode), .command(command), .bgcr(bgcr),
        .adma_addr(adma_addr), .start_flag(start_flag), .irq(irq)
    );

    always #5 CLK = ~CLK;

    task automatic cpu_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        reg_address = a;
        reg_wr_data = d;
        reg_wr_strb = s;
        reg_wr_en   = 1'b1;
        @(negedge CLK);
        reg_wr_en   = 1'b0;
        reg_wr_strb = 4'b0000;
    endtask

    task automatic cpu_read(input logic [11:0] a, output logic [31:0] d,
                            output logic v, output logic v_after);
        reg_address = a;
        reg_rd_en   = 1'b1;
        @(negedge CLK);
        reg_rd_en   = 1'b0;
        d = reg_rd_data;
        v = reg_rd_valid;
        @(negedge CLK);
        v_after = reg_rd_valid;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic v, va;
        logic [11:0] addrs [3];
        addrs[0] = 12'h004; addrs[1] = 12'h030; addrs[2] = 12'h058;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({irq, start_flag, reg_rd_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {irq, start_flag, reg_rd_valid});
        end
        checks++;
        if ({blk_size, blk_cnt, argument, command} !== 76'd0) begin
            failures++; $display("FAIL reset_regs: got %h expected 0", {blk_size, blk_cnt, argument, command});
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_read(addrs[i], d, v, va);
            checks++;
            if (d !== 32'd0 || v !== 1'b1 || va !== 1'b0) begin
                failures++; $display("FAIL reset_read %h: data %h valid %b/%b expected 0 1/0", addrs[i], d, v, va);
            end
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_blk_cnt;
        logic [31:0] d;
        logic v, va;
        cpu_write(12'h004, 32'h0001_0200, 4'b0011);
        checks++;
        if (blk_size !== 12'h200 || blk_cnt !== 16'h0) begin
            failures++; $display("FAIL bsr_write: size %h cnt %h expected 200 0000", blk_size, blk_cnt);
        end
        cpu_write(12'h004, 32'h0001_0000, 4'b1100);
        checks++;
        if (blk_cnt !== 16'h1) begin failures++; $display("FAIL bcr_write: got %h expected 0001", blk_cnt); end
        blk_cnt_dec = 1'b1;
        repeat (2) @(negedge CLK);
        blk_cnt_dec = 1'b0;
        checks++;
        if (blk_cnt !== 16'h0) begin failures++; $display("FAIL bcr_saturate: got %h expected 0000", blk_cnt); end
        // CPU write and decrement together: the written value survives.
        blk_cnt_dec = 1'b1;
        cpu_write(12'h004, 32'h0005_0000, 4'b1100);
        blk_cnt_dec = 1'b0;
        checks++;
        if (blk_cnt !== 16'h5) begin failures++; $display("FAIL bcr_wr_wins: got %h expected 0005", blk_cnt); end
        blk_cnt_dec = 1'b1;
        @(negedge CLK);
        blk_cnt_dec = 1'b0;
        checks++;
        if (blk_cnt !== 16'h4) begin failures++; $display("FAIL bcr_dec: got %h expected 0004", blk_cnt); end
        cpu_write(12'h004, 32'h0000_FFFF, 4'b0011);
        cpu_read(12'h004, d, v, va);
        checks++;
        if (d !== 32'h0004_0FFF || blk_size !== 12'hFFF) begin
            failures++; $display("FAIL bsr_upper: read %h size %h expected 00040fff fff", d, blk_size);
        end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic v, va;
        cpu_write(12'h034, 32'h0000_0005, 4'b1111);
        cpu_write(12'h038, 32'h0000_0001, 4'b1111);
        nisr_set = 15'h0001;
        @(negedge CLK);
        nisr_set = 15'h0000;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag: got %b expected 0", irq); end
        @(negedge CLK);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b expected 1", irq); end
        cpu_read(12'h030, d, v, va);
        checks++;
        if (d !== 32'h0000_0001) begin failures++; $display("FAIL nisr_read: got %h expected 00000001", d); end
        // clear and set in one cycle: set wins
        nisr_set = 15'h0001;
        cpu_write(12'h030, 32'h0000_0001, 4'b1111);
        nisr_set = 15'h0000;
        cpu_read(12'h030, d, v, va);
        checks++;
        if (d !== 32'h0000_0001) begin failures++; $display("FAIL set_wins: got %h expected 00000001", d); end
        // bit 1 not status-enabled, bit 2 enabled but not signalled
        nisr_set = 15'h0006;
        @(negedge CLK);
        nisr_set = 15'h0000;
        cpu_write(12'h030, 32'h0000_0001, 4'b0001);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(negedge CLK);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b expected 0", irq); end
        cpu_read(12'h030, d, v, va);
        checks++;
        if (d !== 32'h0000_0004) begin failures++; $display("FAIL nisr_enable: got %h expected 00000004", d); end
        cpu_write(12'h030, 32'hFFFF_FFFF, 4'b1111);
    endtask

    task automatic test_start_flag;
        logic [31:0] d;
        logic v, va;
        psr_in = 32'h0;
        cpu_write(12'h00C, 32'h1100_0000, 4'b1100);
        checks++;
        if (command !== 16'h1100 || start_flag !== 1'b1) begin
            failures++; $display("FAIL start_pulse: cmd %h start %b expected 1100 1", command, start_flag);
        end
        @(negedge CLK);
        checks++;
        if (start_flag !== 1'b0) begin failures++; $display("FAIL start_width: got %b expected 0", start_flag); end
        cpu_write(12'h034, 32'h1000_0001, 4'b1111);
        psr_in = 32'h1;
        cpu_write(12'h00C, 32'h2200_0077, 4'b1111);
        checks++;
        if (command !== 16'h1100 || transfer_mode !== 16'h0 || start_flag !== 1'b0) begin
            failures++; $display("FAIL cmd_inhibit: cmd %h tmr %h start %b expected 1100 0000 0", command, transfer_mode, start_flag);
        end
        psr_in = 32'h0;
        cpu_read(12'h030, d, v, va);
        checks++;
        if (d !== 32'h1000_8000 || irq !== 1'b0) begin
            failures++; $display("FAIL cmd_inhibit_isr: got %h irq %b expected 10008000 0", d, irq);
        end
        cpu_write(12'h030, 32'hFFFF_FFFF, 4'b1111);
        cpu_read(12'h030, d, v, va);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL eisr_w1c: got %h expected 00000000", d); end
    endtask

    task automatic test_back_to_back;
        reg_address = 12'h00C;
        reg_wr_data = 32'h3300_0000;
        reg_wr_strb = 4'b1000;
        reg_wr_en   = 1'b1;
        @(negedge CLK);
        checks++;
        if (start_flag !== 1'b1 || command !== 16'h3300) begin
            failures++; $display("FAIL b2b_first: start %b cmd %h expected 1 3300", start_flag, command);
        end
        reg_wr_data = 32'h4400_0000;
        @(negedge CLK);
        reg_wr_en = 1'b0;
        checks++;
        if (start_flag !== 1'b1 || command !== 16'h4400) begin
            failures++; $display("FAIL b2b_second: start %b cmd %h expected 1 4400", start_flag, command);
        end
        @(negedge CLK);
        checks++;
        if (start_flag !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b expected 0", start_flag); end
    endtask

    task automatic test_resp;
        logic [31:0] d;
        logic v, va;
        resp_wr_data = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        resp_wr_en   = 4'b0010;
        @(negedge CLK);
        resp_wr_en   = 4'b0000;
        cpu_read(12'h014, d, v, va);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL resp1: got %h expected deadbeef", d); end
        cpu_read(12'h010, d, v, va);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL resp0: got %h expected 00000000", d); end
        cpu_write(12'h014, 32'h1234_5678, 4'b1111);
        cpu_read(12'h017, d, v, va);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL resp_ro: got %h expected deadbeef", d); end
        cpu_write(12'h020, 32'hFFFF_FFFF, 4'b1111);
        cpu_read(12'h020, d, v, va);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped: got %h expected 00000000", d); end
    endtask

    task automatic test_protect;
        logic [31:0] d;
        logic v, va;
        cpu_write(12'h034, 32'h3000_0001, 4'b1111);
        psr_in = 32'h2;
        cpu_write(12'h008, 32'h1234_5678, 4'b1111);
        psr_in = 32'h0;
        cpu_read(12'h030, d, v, va);
`ifdef SD_HOST_REG_WR_PROTECT_EN
        checks++;
        if (argument !== 32'h0 || d !== 32'h2000_8000) begin
            failures++; $display("FAIL wr_protect: arg %h isr %h expected 00000000 20008000", argument, d);
        end
`else
        checks++;
        if (argument !== 32'h1234_5678 || d !== 32'h0) begin
            failures++; $display("FAIL wr_noprotect: arg %h isr %h expected 12345678 00000000", argument, d);
        end
`endif
        cpu_write(12'h030, 32'hFFFF_FFFF, 4'b1111);
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] d;
        logic v, va;
        cpu_write(12'h008, 32'h0F0F_0F0F, 4'b1111);
        reg_address = 12'h008;
        reg_wr_data = 32'hAAAA_5555;
        reg_wr_strb = 4'b1111;
        reg_wr_en   = 1'b1;
        reg_rd_en   = 1'b1;
        @(negedge CLK);
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        checks++;
        if (reg_rd_data !== 32'h0F0F_0F0F || reg_rd_valid !== 1'b1) begin
            failures++; $display("FAIL rw_same: got %h valid %b expected 0f0f0f0f 1", reg_rd_data, reg_rd_valid);
        end
        cpu_write(12'h008, 32'hFFFF_FFFF, 4'b0100);
        cpu_read(12'h008, d, v, va);
        checks++;
        if (d !== 32'hAAFF_5555 || argument !== 32'hAAFF_5555) begin
            failures++; $display("FAIL byte_strobe: read %h arg %h expected aaff5555", d, argument);
        end
    endtask

    task automatic test_adma_bgcr;
        logic [31:0] d;
        logic v, va;
        cpu_write(12'h058, 32'h89AB_CDEF, 4'b1111);
        cpu_write(12'h05C, 32'h0123_4567, 4'b1111);
        checks++;
        if (adma_addr !== 64'h0123_4567_89AB_CDEF) begin
            failures++; $display("FAIL adma_addr: got %h expected 0123456789abcdef", adma_addr);
        end
        cpu_read(12'h05C, d, v, va);
        checks++;
        if (d !== 32'h0123_4567) begin failures++; $display("FAIL adma_hi_read: got %h expected 01234567", d); end
        adma_err_in = 8'h5A;
        adma_err_ld = 1'b1;
        @(negedge CLK);
        adma_err_ld = 1'b0;
        cpu_write(12'h054, 32'hFFFF_FFFF, 4'b1111);
        cpu_read(12'h054, d, v, va);
        checks++;
        if (d !== 32'h0000_005A) begin failures++; $display("FAIL adma_err: got %h expected 0000005a", d); end
        cpu_write(12'h028, 32'hBEEF_1234, 4'b1111);
        cpu_read(12'h028, d, v, va);
        checks++;
        if (bgcr !== 16'hBEEF || d !== 32'hBEEF_0000) begin
            failures++; $display("FAIL bgcr: out %h read %h expected beef beef0000", bgcr, d);
        end
    endtask

    task automatic test_reset_mid;
        RESET       = 1'b1;
        reg_address = 12'h00C;
        reg_wr_data = 32'h5500_0000;
        reg_wr_strb = 4'b1000;
        reg_wr_en   = 1'b1;
        reg_rd_en   = 1'b1;
        @(negedge CLK);
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        checks++;
        if ({reg_rd_valid, start_flag} !== 2'b00 || command !== 16'h0 || argument !== 32'h0) begin
            failures++; $display("FAIL reset_mid: valid %b start %b cmd %h arg %h expected 0 0 0000 00000000",
                                 reg_rd_valid, start_flag, command, argument);
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        test_reset;
        test_blk_cnt;
        test_irq;
        test_start_flag;
        test_back_to_back;
        test_resp;
        test_protect;
        test_rw_same_cycle;
        test_adma_bgcr;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
